// File: rtl/tile_cursor.sv
// Tile cursor: tracks the tile column/row and the offset inside the tile for each pixel on de_i.
// Optional geometry measurement (act_w_o/act_h_o/geom_err_o) is enabled by TILE_CURSOR_MEASURE_EN.
module tile_cursor #(
    parameter int unsigned HP    = 1920,
    parameter int unsigned VP    = 1080,
    parameter int unsigned KH    = 30,
    parameter int unsigned KV    = 30,
    parameter int unsigned HBLKS = (HP + KH - 1) / KH,
    parameter int unsigned VBLKS = (VP + KV - 1) / KV
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 hs_i,
    input  logic                                 vs_i,
    input  logic                                 de_i,
    output logic                                 de_fall_o,
    output logic                                 h_save_o,
    output logic                                 v_save_o,
    output logic [$clog2(HBLKS+1)-1:0]           ht_cur_o,
    output logic [$clog2(VBLKS+1)-1:0]           vt_cur_o,
    output logic [$clog2(KH+1)-1:0]              hp_cur_o,
    output logic [$clog2(KV+1)-1:0]              vp_cur_o,
    output logic [$clog2(HBLKS*VBLKS+1)-1:0]     tile_idx_o,
    output logic                                 frame_done_o,
    output logic [$clog2(HP+2):0]                act_w_o,
    output logic [$clog2(VP+2):0]                act_h_o,
    output logic                                 geom_err_o
);

    localparam int unsigned HXW = $clog2(HP+1);
    localparam int unsigned VXW = $clog2(VP+1);
    localparam int unsigned HTW = $clog2(HBLKS+1);
    localparam int unsigned VTW = $clog2(VBLKS+1);
    localparam int unsigned HPW = $clog2(KH+1);
    localparam int unsigned VPW = $clog2(KV+1);
    localparam int unsigned TIW = $clog2(HBLKS*VBLKS+1);
    localparam int unsigned AWW = $clog2(HP+2) + 1;
    localparam int unsigned AHW = $clog2(VP+2) + 1;

    localparam logic [HXW-1:0] HX_END  = HXW'(HP);
    localparam logic [HXW-1:0] HX_LAST = HXW'(HP-1);
    localparam logic [VXW-1:0] VX_END  = VXW'(VP);
    localparam logic [VXW-1:0] VX_LAST = VXW'(VP-1);
    localparam logic [HPW-1:0] HP_LAST = HPW'(KH-1);
    localparam logic [VPW-1:0] VP_LAST = VPW'(KV-1);
    localparam logic [HTW-1:0] HT_LAST = HTW'(HBLKS-1);
    localparam logic [VTW-1:0] VT_LAST = VTW'(VBLKS-1);

    logic           de_r;
    logic [HXW-1:0] hx;
    logic [VXW-1:0] vx;
    logic           done_seen;
    logic           pix_vld;
    logic           line_vld;

    assign de_fall_o    = de_r & ~de_i;
    assign pix_vld      = de_i & (hx < HX_END);
    assign line_vld     = de_fall_o & (vx < VX_END);
    assign h_save_o     = pix_vld & ((hp_cur_o == HP_LAST) | (hx == HX_LAST));
    assign v_save_o     = line_vld & ((vp_cur_o == VP_LAST) | (vx == VX_LAST));
    assign frame_done_o = v_save_o & (vt_cur_o == VT_LAST) & ~done_seen;
    assign tile_idx_o   = TIW'(vt_cur_o) * TIW'(HBLKS) + TIW'(ht_cur_o);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            de_r      <= 1'b0;
            hx        <= '0;
            vx        <= '0;
            hp_cur_o  <= '0;
            ht_cur_o  <= '0;
            vp_cur_o  <= '0;
            vt_cur_o  <= '0;
            done_seen <= 1'b0;
        end else begin
            de_r <= de_i;

            if (hs_i)
                hx <= '0;
            else if (de_i && hx != HX_END)
                hx <= hx + 1'b1;

            if (!de_i) begin
                hp_cur_o <= '0;
                ht_cur_o <= '0;
            end else if (pix_vld) begin
                hp_cur_o <= h_save_o ? '0 : hp_cur_o + 1'b1;
                if (h_save_o && ht_cur_o != HT_LAST)
                    ht_cur_o <= ht_cur_o + 1'b1;
            end

            // vs_i wins over a coincident line end
            if (vs_i) begin
                vx        <= '0;
                vp_cur_o  <= '0;
                vt_cur_o  <= '0;
                done_seen <= 1'b0;
            end else if (de_fall_o) begin
                if (vx != VX_END)
                    vx <= vx + 1'b1;
                if (line_vld) begin
                    vp_cur_o <= v_save_o ? '0 : vp_cur_o + 1'b1;
                    if (v_save_o && vt_cur_o != VT_LAST)
                        vt_cur_o <= vt_cur_o + 1'b1;
                end
                if (frame_done_o)
                    done_seen <= 1'b1;
            end
        end
    end

`ifdef TILE_CURSOR_MEASURE_EN
    localparam logic [AWW-1:0] AW_SAT = AWW'(HP+1);
    localparam logic [AWW-1:0] AW_NOM = AWW'(HP);
    localparam logic [AHW-1:0] AH_SAT = AHW'(VP+1);
    localparam logic [AHW-1:0] AH_NOM = AHW'(VP);

    logic           vs_r;
    logic [AWW-1:0] wcnt;
    logic [AWW-1:0] first_w;
    logic [AHW-1:0] hcnt;
    logic           have_first;
    logic           err_acc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vs_r       <= 1'b0;
            wcnt       <= '0;
            first_w    <= '0;
            hcnt       <= '0;
            have_first <= 1'b0;
            err_acc    <= 1'b0;
            act_w_o    <= '0;
            act_h_o    <= '0;
            geom_err_o <= 1'b0;
        end else begin
            vs_r <= vs_i;
            if (vs_i && !vs_r) begin
                act_w_o    <= first_w;
                act_h_o    <= hcnt;
                geom_err_o <= err_acc | (hcnt != AH_NOM);
            end
            if (vs_i) begin
                wcnt       <= '0;
                first_w    <= '0;
                hcnt       <= '0;
                have_first <= 1'b0;
                err_acc    <= 1'b0;
            end else if (de_fall_o) begin
                wcnt <= '0;
                if (hcnt != AH_SAT)
                    hcnt <= hcnt + 1'b1;
                if (!have_first) begin
                    first_w    <= wcnt;
                    have_first <= 1'b1;
                end
                if (wcnt != AW_NOM)
                    err_acc <= 1'b1;
            end else if (de_i && wcnt != AW_SAT) begin
                wcnt <= wcnt + 1'b1;
            end
        end
    end
`else
    assign act_w_o    = AWW'(HP);
    assign act_h_o    = AHW'(VP);
    assign geom_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_tile_cursor.sv
// Directed bench for tile_cursor at HP=8, VP=6, KH=3, KV=4 (3x2 tiles).
// Measurement checks follow TILE_CURSOR_MEASURE_EN.
module tb_tile_cursor;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       hs_i  = 1'b0;
    logic       vs_i  = 1'b0;
    logic       de_i  = 1'b0;
    logic       de_fall_o, h_save_o, v_save_o, frame_done_o, geom_err_o;
    logic [1:0] ht_cur_o, vt_cur_o, hp_cur_o;
    logic [2:0] vp_cur_o, tile_idx_o;
    logic [4:0] act_w_o;
    logic [3:0] act_h_o;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk_i = ~clk_i;

    tile_cursor #(.HP(8), .VP(6), .KH(3), .KV(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .hs_i(hs_i), .vs_i(vs_i), .de_i(de_i),
        .de_fall_o(de_fall_o), .h_save_o(h_save_o), .v_save_o(v_save_o),
        .ht_cur_o(ht_cur_o), .vt_cur_o(vt_cur_o), .hp_cur_o(hp_cur_o), .vp_cur_o(vp_cur_o),
        .tile_idx_o(tile_idx_o), .frame_done_o(frame_done_o),
        .act_w_o(act_w_o), .act_h_o(act_h_o), .geom_err_o(geom_err_o)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are observed 1ns later.
    task automatic drive(input bit rst, input bit hs, input bit vs, input bit de);
        @(posedge clk_i);
        #1;
        rst_i = rst; hs_i = hs; vs_i = vs; de_i = de;
        #1;
    endtask

    task automatic vsync();
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
    endtask

    task automatic check_meas(input int unsigned w, input int unsigned h, input int unsigned e);
`ifdef TILE_CURSOR_MEASURE_EN
        check("act_w", act_w_o, w);
        check("act_h", act_h_o, h);
        check("geom_err", geom_err_o, e);
`else
        check("act_w", act_w_o, 8);
        check("act_h", act_h_o, 6);
        check("geom_err", geom_err_o, 0);
`endif
    endtask

    // One line of n pixels preceded by an hs cycle and followed by the de fall cycle.
    task automatic run_line(input int n, input int vt_e, input int vp_e,
                            input bit vsave_e, input bit fd_e);
        int hp_e, ht_e;
        bit hsv_e;
        drive(0, 1, 0, 0);
        for (int p = 0; p < n; p++) begin
            drive(0, 0, 0, 1);
            if (p < 8) begin
                hp_e  = p % 3;
                ht_e  = p / 3;
                hsv_e = (p % 3 == 2) || (p == 7);
            end else begin
                hp_e  = 0;
                ht_e  = 2;
                hsv_e = 0;
            end
            check("hp_cur", hp_cur_o, hp_e);
            check("ht_cur", ht_cur_o, ht_e);
            check("h_save", h_save_o, hsv_e);
            check("tile_idx", tile_idx_o, vt_e * 3 + ht_e);
            if (p == 0) check("vt_cur", vt_cur_o, vt_e);
        end
        drive(0, 0, 0, 0);
        check("de_fall", de_fall_o, 1);
        check("vp_cur@fall", vp_cur_o, vp_e);
        check("v_save", v_save_o, vsave_e);
        check("frame_done", frame_done_o, fd_e);
    endtask

    task automatic run_frame();
        for (int i = 0; i < 6; i++)
            run_line(8, (i < 4) ? 0 : 1, i % 4, (i == 3) || (i == 5), i == 5);
    endtask

    initial begin
        // reset asserted while de_i is high
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 1);
        drive(0, 0, 0, 1);
        check("rst de_fall", de_fall_o, 0);
        check("rst hp_cur", hp_cur_o, 0);
        check("rst ht_cur", ht_cur_o, 0);
        check("rst vp_cur", vp_cur_o, 0);
        check("rst vt_cur", vt_cur_o, 0);
        check("rst tile_idx", tile_idx_o, 0);
        check("rst h_save", h_save_o, 0);
        check("rst v_save", v_save_o, 0);
        check("rst frame_done", frame_done_o, 0);
`ifdef TILE_CURSOR_MEASURE_EN
        check_meas(0, 0, 0);
`else
        check_meas(8, 6, 0);
`endif
        drive(0, 0, 0, 0);

        // nominal frame
        vsync();
        run_frame();
        vsync();
        check_meas(8, 6, 0);

        // over-long line: pixels 8 and 9 are invalid
        run_line(10, 0, 0, 0, 0);
        vsync();
        check_meas(9, 1, 1);

        // vs_i mid-line 3 abandons the frame
        run_line(8, 0, 0, 0, 0);
        run_line(8, 0, 1, 0, 0);
        drive(0, 1, 0, 0);
        for (int p = 0; p < 4; p++) drive(0, 0, 0, 1);
        drive(0, 0, 1, 1);
        check("mid vp_cur", vp_cur_o, 2);
        drive(0, 0, 1, 0);
        check("vs vt_cur", vt_cur_o, 0);
        check("vs vp_cur", vp_cur_o, 0);
        check("vs v_save", v_save_o, 0);
        check("vs frame_done", frame_done_o, 0);
        drive(0, 0, 0, 0);
        run_frame();
        vsync();
        check_meas(8, 6, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
